// File: rtl/dispatch_unit.sv
// In-order two-lane dispatch buffer between rename and the issue queues.
// Optional head-stall counter is built when DISPATCH_PERF_CNT_EN is defined.

typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
} decode_info_t;

typedef struct packed {
    logic [5:0]  rob_idx;
    logic [31:0] imm;
} data_t;

module dispatch_unit #(
    parameter int unsigned IQ_NUM    = 4,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned IQ_SEL_W  = $clog2(IQ_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [1:0]                    in_valid_i,
    input  decode_info_t [1:0]            in_di_i,
    input  data_t [1:0]                   in_data_i,
    input  logic [1:0][IQ_SEL_W-1:0]      in_iq_sel_i,
    output logic                          in_ready_o,
    output decode_info_t [1:0]            p_di_o,
    output data_t [1:0]                   p_data_o,
    output logic [1:0]                    p_valid_o,
    output logic [IQ_NUM-1:0][1:0]        choose_o,
    input  logic [IQ_NUM-1:0]             iq_ready_i,
    output logic [$clog2(BUF_DEPTH):0]    buf_cnt_o,
    output logic [31:0]                   stall_cnt_o
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    decode_info_t        di_q   [BUF_DEPTH];
    data_t               data_q [BUF_DEPTH];
    logic [IQ_SEL_W-1:0] sel_q  [BUF_DEPTH];

    logic [PTR_W-1:0]    head, tail, head1, tail1;
    logic [CNT_W-1:0]    count, enq_n, deq_n;
    logic                has0, has1, d0, d1, enq0, enq1;
    logic [IQ_SEL_W-1:0] sel0, sel1;

    // Dispatch and enqueue decisions from registered occupancy.
    always_comb begin
        head1      = head + PTR_W'(1);
        tail1      = tail + PTR_W'(1);
        has0       = count >= CNT_W'(1);
        has1       = count >= CNT_W'(2);
        sel0       = sel_q[head];
        sel1       = sel_q[head1];
        d0         = has0 && iq_ready_i[sel0];
        // An IQ takes one instruction per cycle, so a same-IQ pair splits.
        d1         = d0 && has1 && iq_ready_i[sel1] && (sel1 != sel0);
        in_ready_o = count <= CNT_W'(BUF_DEPTH - 2);
        enq0       = in_ready_o && in_valid_i[0];
        enq1       = enq0 && in_valid_i[1];
        enq_n      = CNT_W'(enq0) + CNT_W'(enq1);
        deq_n      = CNT_W'(d0) + CNT_W'(d1);
    end

    // Lane outputs; payload of unoccupied slots is forced to zero.
    always_comb begin
        p_valid_o = {d1, d0};
        p_di_o    = '0;
        p_data_o  = '0;
        if (has0) begin
            p_di_o[0]   = di_q[head];
            p_data_o[0] = data_q[head];
        end
        if (has1) begin
            p_di_o[1]   = di_q[head1];
            p_data_o[1] = data_q[head1];
        end
        for (int q = 0; q < int'(IQ_NUM); q++) begin
            choose_o[q][0] = d0 && (sel0 == IQ_SEL_W'(q));
            choose_o[q][1] = d1 && (sel1 == IQ_SEL_W'(q));
        end
        buf_cnt_o = count;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    // Entry storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (enq0 && !(rst || flush)) begin
            di_q[tail]   <= in_di_i[0];
            data_q[tail] <= in_data_i[0];
            sel_q[tail]  <= in_iq_sel_i[0];
        end
        if (enq1 && !(rst || flush)) begin
            di_q[tail1]   <= in_di_i[1];
            data_q[tail1] <= in_data_i[1];
            sel_q[tail1]  <= in_iq_sel_i[1];
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the head waits on its IQ; flush keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (has0 && !d0 && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: expected instructions are queued on enqueue
// and popped by a negedge monitor as lanes dispatch.

module tb_dispatch_unit;
    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } tb_di_t;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] imm;
    } tb_data_t;

    typedef struct {
        tb_di_t     di;
        tb_data_t   data;
        logic [1:0] sel;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      in_valid;
    tb_di_t [1:0]    in_di;
    tb_data_t [1:0]  in_data;
    logic [1:0][1:0] in_sel;
    logic            in_ready;
    tb_di_t [1:0]    p_di;
    tb_data_t [1:0]  p_data;
    logic [1:0]      p_valid;
    logic [3:0][1:0] choose;
    logic [3:0]      iq_ready;
    logic [2:0]      buf_cnt;
    logic [31:0]     stall_cnt;

    int    total = 0;
    int    bad   = 0;
    int    tag   = 0;
    item_t exp_q[$];
    item_t mon_it;
    logic [3:0] mon_col;

    dispatch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (in_valid),
        .in_di_i     (in_di),
        .in_data_i   (in_data),
        .in_iq_sel_i (in_sel),
        .in_ready_o  (in_ready),
        .p_di_o      (p_di),
        .p_data_o    (p_data),
        .p_valid_o   (p_valid),
        .choose_o    (choose),
        .iq_ready_i  (iq_ready),
        .buf_cnt_o   (buf_cnt),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every dispatched lane must be the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (p_valid[1] === 1'b1 && p_valid[0] !== 1'b1) begin
                total++; bad++;
                $display("FAIL order: p_valid=%b lane1 without lane0", p_valid);
            end
            for (int l = 0; l < 2; l++) begin
                for (int q = 0; q < 4; q++) mon_col[q] = choose[q][l];
                if (p_valid[l] === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_dispatch: lane%0d opcode=%h with empty scoreboard", l, p_di[l].opcode);
                    end else begin
                        mon_it = exp_q.pop_front();
                        if (p_di[l] !== mon_it.di || p_data[l] !== mon_it.data ||
                            mon_col !== (4'(1) << mon_it.sel)) begin
                            bad++;
                            $display("FAIL payload lane%0d: got di=%h data=%h choose=%b, want di=%h data=%h choose=%b",
                                     l, p_di[l], p_data[l], mon_col, mon_it.di, mon_it.data, 4'(1) << mon_it.sel);
                        end
                    end
                end else begin
                    total++;
                    if (mon_col !== 4'b0000) begin
                        bad++;
                        $display("FAIL choose_idle lane%0d: got %b want 0000", l, mon_col);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 2'b00;
        in_di    = '0;
        in_data  = '0;
        in_sel   = '0;
    endtask

    task automatic offer(input logic [1:0] v, input logic [1:0] s0, input logic [1:0] s1, input bit acc);
        item_t it;
        in_valid = v;
        for (int l = 0; l < 2; l++) begin
            tag++;
            in_di[l]   = tb_di_t'({8'(tag), 15'(tag * 7 + 3)});
            in_data[l] = tb_data_t'({6'(tag), 32'(tag * 40503 + 11)});
            in_sel[l]  = (l == 0) ? s0 : s1;
            if (acc && v[l]) begin
                it.di   = in_di[l];
                it.data = in_data[l];
                it.sel  = in_sel[l];
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; iq_ready = 4'hF; idle();
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", buf_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++; if (p_valid !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b want 00", p_valid); end
        total++; if (choose !== '0) begin bad++; $display("FAIL reset_choose: got %h want 0", choose); end
        total++; if (p_di !== '0 || p_data !== '0) begin bad++; $display("FAIL reset_payload: got %h/%h want 0", p_di, p_data); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_pair();
        cyc(); iq_ready = 4'hF; offer(2'b11, 2'd0, 2'd1, 1'b1);
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL pair_latency: got cnt %0d want 0", buf_cnt); end
        cyc(); idle();
        @(negedge clk);
        total++; if (p_valid !== 2'b11) begin bad++; $display("FAIL pair_valid: got %b want 11", p_valid); end
        total++; if (choose[0] !== 2'b01 || choose[1] !== 2'b10) begin bad++; $display("FAIL pair_choose: got %b/%b want 01/10", choose[0], choose[1]); end
        total++; if (buf_cnt !== 3'd2) begin bad++; $display("FAIL pair_cnt: got %0d want 2", buf_cnt); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0 || p_valid !== 2'b00) begin bad++; $display("FAIL pair_drained: got cnt %0d valid %b want 0/00", buf_cnt, p_valid); end
    endtask

    task automatic test_same_iq();
        cyc(); iq_ready = 4'hF; offer(2'b11, 2'd2, 2'd2, 1'b1);
        cyc(); idle();
        @(negedge clk);
        total++; if (p_valid !== 2'b01 || choose[2] !== 2'b01) begin bad++; $display("FAIL same_iq_c1: got valid %b choose2 %b want 01/01", p_valid, choose[2]); end
        cyc();
        @(negedge clk);
        total++; if (p_valid !== 2'b01 || buf_cnt !== 3'd1) begin bad++; $display("FAIL same_iq_c2: got valid %b cnt %0d want 01/1", p_valid, buf_cnt); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL same_iq_end: got cnt %0d want 0", buf_cnt); end
    endtask

    task automatic test_head_blocked();
        logic [31:0] exp_stall;
`ifdef DISPATCH_PERF_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        cyc(); iq_ready = 4'b0111; offer(2'b11, 2'd3, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc(); idle();
            @(negedge clk);
            total++; if (p_valid !== 2'b00) begin bad++; $display("FAIL blocked_c%0d: got valid %b want 00", c, p_valid); end
        end
        cyc(); iq_ready = 4'hF;
        @(negedge clk);
        total++; if (p_valid !== 2'b11) begin bad++; $display("FAIL blocked_release: got valid %b want 11", p_valid); end
        total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL blocked_end: got cnt %0d want 0", buf_cnt); end
    endtask

    task automatic test_fill();
        cyc(); iq_ready = 4'h0; offer(2'b11, 2'd1, 2'd2, 1'b1);
        cyc(); offer(2'b11, 2'd3, 2'd0, 1'b1);
        @(negedge clk);
        total++; if (buf_cnt !== 3'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_half: got cnt %0d ready %b want 2/1", buf_cnt, in_ready); end
        cyc(); offer(2'b11, 2'd0, 2'd1, 1'b0);
        @(negedge clk);
        total++; if (buf_cnt !== 3'd4 || in_ready !== 1'b0 || p_valid !== 2'b00) begin bad++; $display("FAIL fill_full: got cnt %0d ready %b valid %b want 4/0/00", buf_cnt, in_ready, p_valid); end
        cyc(); idle();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd4) begin bad++; $display("FAIL fill_reject: got cnt %0d want 4", buf_cnt); end
        cyc(); iq_ready = 4'hF;
        @(negedge clk);
        total++; if (p_valid !== 2'b11) begin bad++; $display("FAIL fill_drain1: got valid %b want 11", p_valid); end
        cyc();
        @(negedge clk);
        total++; if (p_valid !== 2'b11 || buf_cnt !== 3'd2) begin bad++; $display("FAIL fill_drain2: got valid %b cnt %0d want 11/2", p_valid, buf_cnt); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL fill_end: got cnt %0d want 0", buf_cnt); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 6; k++) begin
            cyc(); iq_ready = 4'hF; offer(2'b01, 2'(k), 2'd0, 1'b1);
            @(negedge clk);
            total++;
            if (buf_cnt !== ((k == 0) ? 3'd0 : 3'd1) || p_valid !== ((k == 0) ? 2'b00 : 2'b01)) begin
                bad++; $display("FAIL wrap_k%0d: got cnt %0d valid %b", k, buf_cnt, p_valid);
            end
        end
        cyc(); idle();
        @(negedge clk);
        total++; if (p_valid !== 2'b01) begin bad++; $display("FAIL wrap_last: got valid %b want 01", p_valid); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL wrap_end: got cnt %0d want 0", buf_cnt); end
    endtask

    task automatic test_flush();
        cyc(); iq_ready = 4'h0; offer(2'b11, 2'd0, 2'd1, 1'b1);
        cyc(); offer(2'b01, 2'd2, 2'd0, 1'b1);
        @(negedge clk);
        total++; if (buf_cnt !== 3'd2) begin bad++; $display("FAIL flush_pre: got cnt %0d want 2", buf_cnt); end
        cyc(); flush = 1'b1; offer(2'b11, 2'd3, 2'd3, 1'b0); exp_q.delete();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd3 || in_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle: got cnt %0d ready %b want 3/0", buf_cnt, in_ready); end
        cyc(); flush = 1'b0; idle(); iq_ready = 4'hF;
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0 || p_valid !== 2'b00 || in_ready !== 1'b1 || choose !== '0) begin
            bad++; $display("FAIL flush_after: got cnt %0d valid %b ready %b choose %h", buf_cnt, p_valid, in_ready, choose);
        end
        cyc();
        @(negedge clk);
        total++; if (p_valid !== 2'b00 || buf_cnt !== 3'd0) begin bad++; $display("FAIL flush_stale: got valid %b cnt %0d want 00/0", p_valid, buf_cnt); end
    endtask

    task automatic test_back_to_back();
        int   sz;
        int   r;
        int   n;
        logic exp_rdy;
        for (int c = 0; c < 40; c++) begin
            cyc();
            sz       = exp_q.size();
            exp_rdy  = (sz <= 2);
            iq_ready = 4'($urandom_range(0, 15));
            r        = $urandom_range(0, 2);
            offer((r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), exp_rdy);
            @(negedge clk);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
            total++; if (buf_cnt !== 3'(sz)) begin bad++; $display("FAIL b2b_cnt c%0d: got %0d want %0d", c, buf_cnt, sz); end
        end
        cyc(); idle(); iq_ready = 4'hF;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            cyc();
            n++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: %0d entries never dispatched", exp_q.size()); end
        cyc();
        @(negedge clk);
        total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL b2b_end: got cnt %0d want 0", buf_cnt); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_same_iq();
        test_head_blocked();
        test_fill();
        test_wrap();
        test_flush();
        test_back_to_back();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover: %0d expected entries remain", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
